// File: rtl/timing_scheduler.sv
// Pixel-rate prescaler, timing-counter enables, shader start/deadline control and program-load window.
// Optional: define TIMING_SCHEDULER_FRAME_CNT_EN to add the frame_count output (width FRAME_CNT_WIDTH).
module timing_scheduler #(
  parameter int CYCLES_PER_PIXEL = 4
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
  ,
  parameter int FRAME_CNT_WIDTH  = 8
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       fast,
  input  logic       h_next,
  input  logic       v_next,
  input  logic       h_blank,
  input  logic       v_blank,
  output logic       h_enable,
  output logic       v_enable,
  output logic       inc_1_or_4,
  output logic       shader_start,
  input  logic       shader_done,
  output logic       pixel_strobe,
  output logic       underrun,
  input  logic       underrun_clr,
  input  logic       load_req,
  output logic       load_grant,
  input  logic       load_done,
  output logic [1:0] state
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SYNC = 2'b01,
    RUN  = 2'b10,
    LOAD = 2'b11
  } state_e;

  localparam int PW = (CYCLES_PER_PIXEL > 1) ? $clog2(CYCLES_PER_PIXEL) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_PIXEL - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          fast_q, fast_d;
  logic          underrun_q, underrun_d;

  logic tick, frame_end, active, deadline, miss;

  assign tick       = (state_q != IDLE) && (phase_q == PHASE_LAST);
  assign frame_end  = tick && h_next && v_next;
  assign active     = !h_blank && !v_blank;
  // The deadline for a pixel is its own tick: done must have arrived strictly before it.
  assign deadline   = (state_q == RUN) && tick && active;
  assign miss       = deadline && busy_q;

  assign h_enable     = tick;
  assign v_enable     = tick && h_next;
  assign inc_1_or_4   = fast_q;
  assign shader_start = (state_q == RUN) && (phase_q == '0) && active;
  assign pixel_strobe = deadline && !busy_q;
  assign underrun     = underrun_q;
  assign load_grant   = (state_q == LOAD);
  assign state        = state_q;

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (run) state_d = SYNC;
      SYNC: if (frame_end) state_d = run ? RUN : IDLE;
      RUN: begin
        if (frame_end) begin
          if (!run)          state_d = IDLE;
          else if (load_req) state_d = LOAD;
        end
      end
      LOAD: if (load_done) state_d = run ? SYNC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d = '0;
    if (state_q != IDLE) phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);

    busy_d = busy_q;
    if (shader_done || miss) busy_d = 1'b0;
    if (shader_start)        busy_d = 1'b1;
    if (state_q == RUN && state_d == LOAD) busy_d = 1'b0;

    // A new miss outranks a simultaneous clear so no underrun is ever lost.
    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (miss)         underrun_d = 1'b1;

    fast_d = frame_end ? fast : fast_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      busy_q     <= 1'b0;
      fast_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      fast_q     <= fast_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_end && state_q == RUN) frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_count_q <= '0;
    else          frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_timing_scheduler.sv
// Self-checking bench for timing_scheduler: the bench plays the timing counters and the shader,
// and a cycle-level reference model built from the frame/pixel rules predicts every output.
module tb_timing_scheduler;

  localparam int CPP     = 4;
  localparam int H_TOTAL = 6;
  localparam int H_ACT   = 4;
  localparam int V_TOTAL = 4;
  localparam int V_ACT   = 3;
  localparam int S_IDLE  = 0;
  localparam int S_SYNC  = 1;
  localparam int S_RUN   = 2;
  localparam int S_LOAD  = 3;
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
  localparam int FCW = 2;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic run, fast, h_next, v_next, h_blank, v_blank;
  logic shader_done, underrun_clr, load_req, load_done;
  logic h_enable, v_enable, inc_1_or_4, shader_start, pixel_strobe, underrun, load_grant;
  logic [1:0] state;
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
  logic [FCW-1:0] frame_count;
`endif

  always #5 clk = ~clk;

  timing_scheduler #(
    .CYCLES_PER_PIXEL(CPP)
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
    , .FRAME_CNT_WIDTH(FCW)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .fast(fast),
    .h_next(h_next), .v_next(v_next), .h_blank(h_blank), .v_blank(v_blank),
    .h_enable(h_enable), .v_enable(v_enable), .inc_1_or_4(inc_1_or_4),
    .shader_start(shader_start), .shader_done(shader_done), .pixel_strobe(pixel_strobe),
    .underrun(underrun), .underrun_clr(underrun_clr),
    .load_req(load_req), .load_grant(load_grant), .load_done(load_done), .state(state)
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode, cycles since leaving IDLE, outstanding shader job, flags, raster position.
  int m_state, m_cnt, m_fc, hx, vy;
  bit m_busy, m_fast, m_under, m_frame_end;
  int done_cnt, done_delay;
  logic manual_done;
  int dut_start_cnt, dut_hen_cnt;

  typedef struct {
    logic       run;
    logic       fast;
    logic       load_req;
    int         done_delay;
    logic [1:0] exp_state;
    logic       exp_under;
    logic       exp_inc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_tick();
    return (m_state != S_IDLE) && ((m_cnt % CPP) == CPP - 1);
  endfunction

  function automatic bit predict_miss();
    return (m_state == S_RUN) && model_tick() && (hx < H_ACT) && (vy < V_ACT) && m_busy;
  endfunction

  // One clock: drive raster/shader inputs, compare at negedge, advance the model at posedge.
  task automatic step();
    bit tick, act, fe, st, deadline, miss, nb, nu, nf;
    int ns;
    h_next      = (hx == H_TOTAL - 1);
    v_next      = (vy == V_TOTAL - 1);
    h_blank     = (hx >= H_ACT);
    v_blank     = (vy >= V_ACT);
    shader_done = manual_done;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) shader_done = 1'b1;
    end
    tick     = model_tick();
    act      = (hx < H_ACT) && (vy < V_ACT);
    fe       = tick && (hx == H_TOTAL - 1) && (vy == V_TOTAL - 1);
    st       = (m_state == S_RUN) && ((m_cnt % CPP) == 0) && act;
    deadline = (m_state == S_RUN) && tick && act;
    miss     = deadline && m_busy;

    @(negedge clk);
    check("h_enable", h_enable, tick);
    check("v_enable", v_enable, tick && (hx == H_TOTAL - 1));
    check("inc_1_or_4", inc_1_or_4, m_fast);
    check("shader_start", shader_start, st);
    check("pixel_strobe", pixel_strobe, deadline && !m_busy);
    check("underrun", underrun, m_under);
    check("load_grant", load_grant, m_state == S_LOAD);
    check("state", state, m_state);
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
    check("frame_count", frame_count, m_fc);
`endif
    dut_start_cnt += shader_start;
    dut_hen_cnt   += h_enable;

    nb = m_busy;
    if (shader_done || miss) nb = 0;
    if (st) nb = 1;
    nu = miss ? 1'b1 : (underrun_clr ? 1'b0 : m_under);
    nf = fe ? fast : m_fast;
    ns = m_state;
    case (m_state)
      S_IDLE: if (run) ns = S_SYNC;
      S_SYNC: if (fe) ns = run ? S_RUN : S_IDLE;
      S_RUN:  if (fe) ns = !run ? S_IDLE : (load_req ? S_LOAD : S_RUN);
      default: if (load_done) ns = run ? S_SYNC : S_IDLE;
    endcase
    if (m_state == S_RUN && ns == S_LOAD) nb = 0;
`ifdef TIMING_SCHEDULER_FRAME_CNT_EN
    if (fe && m_state == S_RUN) m_fc = (m_fc + 1) % (1 << FCW);
`endif
    if (st && done_delay > 0) done_cnt = done_delay;
    m_frame_end = fe;

    @(posedge clk);
    #1;
    m_cnt   = (m_state == S_IDLE) ? 0 : m_cnt + 1;
    m_state = ns;
    m_busy  = nb;
    m_under = nu;
    m_fast  = nf;
    if (tick) begin
      if (hx == H_TOTAL - 1) begin
        hx = 0;
        vy = (vy == V_TOTAL - 1) ? 0 : vy + 1;
      end else begin
        hx++;
      end
    end
  endtask

  task automatic run_to_frame_end(input string name);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!m_frame_end && k < 2000);
    if (!m_frame_end) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no frame end within %0d cycles", name, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int base, k;
    vecs[0] = '{run: 1'b1, fast: 1'b0, load_req: 1'b0, done_delay: 2, exp_state: 2'b10, exp_under: 1'b0, exp_inc: 1'b0};
    vecs[1] = '{run: 1'b1, fast: 1'b0, load_req: 1'b0, done_delay: 2, exp_state: 2'b10, exp_under: 1'b0, exp_inc: 1'b0};
    vecs[2] = '{run: 1'b1, fast: 1'b0, load_req: 1'b0, done_delay: 0, exp_state: 2'b10, exp_under: 1'b1, exp_inc: 1'b0};
    vecs[3] = '{run: 1'b1, fast: 1'b1, load_req: 1'b0, done_delay: 2, exp_state: 2'b10, exp_under: 1'b1, exp_inc: 1'b1};
    vecs[4] = '{run: 1'b1, fast: 1'b0, load_req: 1'b1, done_delay: 2, exp_state: 2'b11, exp_under: 1'b1, exp_inc: 1'b0};

    reset_n = 1'b0;
    run = 1'b0; fast = 1'b0; h_next = 1'b0; v_next = 1'b0; h_blank = 1'b0; v_blank = 1'b0;
    shader_done = 1'b0; underrun_clr = 1'b0; load_req = 1'b0; load_done = 1'b0; manual_done = 1'b0;
    m_state = S_IDLE; m_cnt = 0; m_fc = 0; hx = 0; vy = 0;
    m_busy = 0; m_fast = 0; m_under = 0; m_frame_end = 0;
    done_cnt = 0; done_delay = 0; dut_start_cnt = 0; dut_hen_cnt = 0;

    // Reset: run requested while reset is held must not leave IDLE.
    @(posedge clk);
    #1 run = 1'b1;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_h_enable", h_enable, 0);
    check("rst_start", shader_start, 0);
    check("rst_strobe", pixel_strobe, 0);
    check("rst_underrun", underrun, 0);
    check("rst_grant", load_grant, 0);
    check("rst_inc", inc_1_or_4, 0);
    @(posedge clk);
    #1 run = 1'b0;
    reset_n = 1'b1;
    repeat (3) step();

    // Frame-level vectors: apply inputs, run to the next frame boundary, check the result.
    for (int i = 0; i < 5; i++) begin
      run = vecs[i].run;
      fast = vecs[i].fast;
      load_req = vecs[i].load_req;
      done_delay = vecs[i].done_delay;
      run_to_frame_end($sformatf("vec%0d", i));
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d_underrun", i), underrun, vecs[i].exp_under);
      check($sformatf("vec%0d_inc", i), inc_1_or_4, vecs[i].exp_inc);
    end

    // LOAD window: grant held, no shading for 100 cycles, load_done returns to SYNC then RUN.
    check("load_grant_open", load_grant, 1);
    base = dut_start_cnt;
    repeat (100) step();
    check("no_start_in_load", dut_start_cnt - base, 0);
    load_req = 1'b0;
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    check("load_done_to_sync", state, 2'b01);
    run_to_frame_end("sync_after_load");
    check("sync_to_run", state, 2'b10);

    // Underrun clear, then clear coinciding with a fresh miss.
    done_delay = 2;
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 0);
    done_delay = 0;
    k = 0;
    while (!predict_miss() && k < 500) begin
      step();
      k++;
    end
    check("underrun_before_miss", underrun, 0);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("set_beats_clear", underrun, 1);
    done_delay = 2;
    step();
    while (predict_miss()) step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("underrun_cleared_again", underrun, 0);

    // fast changed mid-frame only takes effect after the frame boundary.
    fast = 1'b1;
    repeat (10) step();
    check("fast_mid_frame", inc_1_or_4, 0);
    run_to_frame_end("fast_frame");
    check("fast_after_frame", inc_1_or_4, 1);
    fast = 1'b0;

    // run dropped mid-frame: the frame completes, then counters freeze in IDLE.
    run = 1'b0;
    repeat (10) step();
    check("run_low_mid_frame", state, 2'b10);
    run_to_frame_end("stop_frame");
    check("stopped_idle", state, 2'b00);
    base = dut_hen_cnt;
    repeat (20) step();
    check("idle_no_h_enable", dut_hen_cnt - base, 0);

    // Restart: one h_enable every CPP cycles in SYNC, RUN one cycle after the frame end.
    run = 1'b1;
    step();
    base = dut_hen_cnt;
    repeat (40) step();
    check("h_enable_cadence", dut_hen_cnt - base, 40 / CPP);
    run_to_frame_end("restart");
    check("restart_run", state, 2'b10);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (run) begin
        if ($urandom_range(0, 199) == 0) run = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        run = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) fast = ~fast;
      load_req     = ($urandom_range(0, 2) == 0);
      load_done    = ($urandom_range(0, 15) == 0);
      underrun_clr = ($urandom_range(0, 31) == 0);
      manual_done  = ($urandom_range(0, 39) == 0);
      done_delay   = $urandom_range(0, 4);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_scheduler.md
Name: timing_scheduler

Overview:
- Sequences the horizontal/vertical timing counter chain and the per-pixel shader core.
- Derives the pixel-rate enable from clk and drives counter enables and step size.
- Issues shader start pulses on active pixels, checks completion deadlines, and grants a program-load window at frame boundaries.
- Sits between the top-level control inputs and the timing counter and shader instances.

Parameters:
CYCLES_PER_PIXEL, 4, clk cycles per pixel tick; legal range 1..16.
FRAME_CNT_WIDTH, 8, width of frame_count (optional feature only).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
run  input  1  1 = operate; 0 = stop at next frame boundary
fast  input  1  step counters by 4 (simulation speed-up); sampled at frame boundary
h_next  input  1  horizontal counter at last pixel of line
v_next  input  1  vertical counter at last line of frame
h_blank  input  1  horizontal blank region
v_blank  input  1  vertical blank region
h_enable  output  1  horizontal counter enable
v_enable  output  1  vertical counter enable
inc_1_or_4  output  1  counter step select to both counters
shader_start  output  1  one-cycle shader start pulse
shader_done  input  1  one-cycle shader completion pulse
pixel_strobe  output  1  pixel result valid, capture now
underrun  output  1  sticky: shader missed its deadline
underrun_clr  input  1  clears underrun
load_req  input  1  program load requested
load_grant  output  1  load window open
load_done  input  1  load finished (pulse)
state  output  2  IDLE=00, SYNC=01, RUN=10, LOAD=11

Behaviour:
- Reset values:
  - state=IDLE, phase=0, busy=0, fast_q=0.
  - All outputs 0.
- Prescaler:
  - phase counts 0..CYCLES_PER_PIXEL-1 and wraps in every state except IDLE; in IDLE it is held at 0.
  - tick = (phase==CYCLES_PER_PIXEL-1) && state!=IDLE.
  - CYCLES_PER_PIXEL=1 gives a tick every cycle.
- Counter control (combinational):
  - h_enable = tick.
  - v_enable = tick && h_next.
  - inc_1_or_4 = fast_q.
- frame_end = tick && h_next && v_next.
- fast_q loads fast on frame_end only, so a mid-frame change of fast has no effect until the next frame.
- active = !h_blank && !v_blank.
- Shader scheduling (RUN only):
  - shader_start is pulsed in the cycle where phase==0 && active. It sets busy the following cycle.
  - shader_done clears busy. done and start in the same cycle leaves busy=1.
- Deadline check, on tick && active in RUN:
  - busy=0 (done already seen): pixel_strobe=1.
  - busy=1: pixel_strobe=0, underrun<=1, busy forced 0.
- Underrun flag:
  - Stays set until underrun_clr.
  - clr and a new set in the same cycle: set wins.
- FSM:
  - IDLE: run=1 -> SYNC.
  - SYNC: counters run, no shader activity. On frame_end: run=0 -> IDLE; else -> RUN.
  - RUN: on frame_end:
    - run=0 -> IDLE.
    - else load_req=1 -> LOAD.
    - else stay in RUN.
  - LOAD: load_grant=1, counters keep running, no shader_start/pixel_strobe, busy cleared on entry. On load_done: run=1 -> SYNC; run=0 -> IDLE.
- run falling mid-frame: the frame completes normally; the stop takes effect at frame_end.
- load_req outside RUN-at-frame_end is ignored; the request must be held until granted.
- IDLE freezes the counters at their current position. SYNC realigns to the next frame boundary before shading.

Optional Feature:
- Macro: TIMING_SCHEDULER_FRAME_CNT_EN.
- Defined:
  - Output port frame_count [FRAME_CNT_WIDTH-1:0], reset 0.
  - Increments on every frame_end while state==RUN; wraps to 0 at all-ones.
  - Holds its value in other states.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run=1, CYCLES_PER_PIXEL=4 -> h_enable high once every 4 clk; state 00->01; 01->10 exactly one cycle after the first frame_end.
- RUN, active pixel, shader_done 2 cycles after shader_start -> pixel_strobe=1 at the tick; underrun stays 0.
- RUN, active pixel, shader_done withheld -> pixel_strobe=0 and underrun=1 at the tick. underrun_clr=1 -> underrun=0 next cycle. clr with a simultaneous new miss -> underrun stays 1.
- load_req=1 held through frame_end -> state=11 and load_grant=1; no shader_start for 100 cycles. load_done pulse -> state=01, then 10 after the next frame_end.
- fast toggled to 1 mid-frame -> inc_1_or_4 stays 0 until frame_end, then 1. run=0 mid-frame -> state=00 only after frame_end; h_enable=0 afterwards.
- With TIMING_SCHEDULER_FRAME_CNT_EN and FRAME_CNT_WIDTH=2 -> frame_count reads 1, 2, 3, 0 after 4 RUN frames; it does not increment while in LOAD.
